trigger_sequencer: RTL

- Parametrised multi-stage trigger engine for the logic capture path; successor to the fixed 8-level trigger logic inside capture.
- Level count, sample width and per-stage occurrence counters are parameters. Per stage: level or edge match per bit, plus a repeat count before the sequence advances.
- Drives triggered and trigger position to the capture/FIFO glue. Samples come in on a sample-enable strobe in the clk domain.

---
 rtl/trigger_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger engine for the logic capture path.
// Each stage matches per-bit levels or edges a programmable number of times, then advances; the last stage fires the trigger.
module trigger_sequencer #(
    parameter int unsigned size    = 32,
    parameter int unsigned levels  = 8,
    parameter int unsigned cnt_w   = 16,
    parameter int unsigned saddr_w = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [size-1:0]             dinput,
    input  logic                        sample_en,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [$clog2(levels):0]     num_levels,
    input  logic [levels*size-1:0]      trig_mask,
    input  logic [levels*size-1:0]      trig_type,
    input  logic [levels*size-1:0]      trig_level,
    input  logic [levels*cnt_w-1:0]     trig_count,
    output logic                        armed,
    output logic                        triggered,
    output logic                        trig_pulse,
    output logic [$clog2(levels)-1:0]   stage,
    output logic [saddr_w-1:0]          trigger_pos
);

    localparam int unsigned SW  = $clog2(levels);
    localparam int unsigned NLW = $clog2(levels) + 1;
    localparam int unsigned CW1 = cnt_w + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [cnt_w-1:0]   occ_q, occ_d;
    logic [saddr_w-1:0] scnt_q, scnt_d;
    logic [size-1:0]    prev_q, prev_d;
    logic [saddr_w-1:0] pos_q, pos_d;
    logic               pulse_q, pulse_d;
    logic               armed_q, triggered_q;

    logic [size-1:0]    cur_mask, cur_type, cur_level, hit_bits;
    logic [cnt_w-1:0]   cur_cnt, cnt_eff;
    logic [NLW-1:0]     nl_eff;
    logic [CW1-1:0]     occ_inc;
    logic [saddr_w-1:0] scnt_inc;
    logic               match, reach, is_last;

    // Select the configuration of the current stage and evaluate its match.
    always_comb begin
        cur_mask  = '0;
        cur_type  = '0;
        cur_level = '0;
        cur_cnt   = '0;
        for (int unsigned k = 0; k < levels; k++) begin
            if (stage_q == SW'(k)) begin
                cur_mask  = trig_mask[k*size +: size];
                cur_type  = trig_type[k*size +: size];
                cur_level = trig_level[k*size +: size];
                cur_cnt   = trig_count[k*cnt_w +: cnt_w];
            end
        end
        // A bit passes if masked out, or at the required value and (for edges) just changed.
        hit_bits = ~cur_mask | (~(dinput ^ cur_level) & (~cur_type | (prev_q ^ dinput)));
        match    = &hit_bits;

        cnt_eff  = (cur_cnt == '0) ? cnt_w'(1) : cur_cnt;
        occ_inc  = {1'b0, occ_q} + CW1'(1);
        reach    = (occ_inc >= {1'b0, cnt_eff});

        if (num_levels == '0) begin
            nl_eff = NLW'(1);
        end else if (num_levels > NLW'(levels)) begin
            nl_eff = NLW'(levels);
        end else begin
            nl_eff = num_levels;
        end
        is_last  = (NLW'(stage_q) == (nl_eff - NLW'(1)));

        scnt_inc = (&scnt_q) ? scnt_q : (scnt_q + saddr_w'(1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        occ_d   = occ_q;
        scnt_d  = scnt_q;
        prev_d  = prev_q;
        pos_d   = pos_q;
        pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stage_d = '0;
                occ_d   = '0;
                scnt_d  = '0;
                if (arm) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // First sample only seeds edge history.
                if (sample_en) begin
                    prev_d  = dinput;
                    scnt_d  = scnt_inc;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sample_en) begin
                    prev_d = dinput;
                    scnt_d = scnt_inc;
                    if (match) begin
                        if (reach) begin
                            if (is_last) begin
                                state_d = ST_DONE;
                                pos_d   = scnt_q;
                                pulse_d = 1'b1;
                            end else begin
                                stage_d = stage_q + SW'(1);
                                occ_d   = '0;
                            end
                        end else begin
                            occ_d = occ_inc[cnt_w-1:0];
                        end
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d = ST_PRIME;
                    stage_d = '0;
                    occ_d   = '0;
                    scnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a trigger in the same cycle.
        if (abort) begin
            state_d = ST_IDLE;
            stage_d = '0;
            occ_d   = '0;
            scnt_d  = '0;
            pos_d   = pos_q;
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            occ_q       <= '0;
            scnt_q      <= '0;
            prev_q      <= '0;
            pos_q       <= '0;
            pulse_q     <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            occ_q       <= occ_d;
            scnt_q      <= scnt_d;
            prev_q      <= prev_d;
            pos_q       <= pos_d;
            pulse_q     <= pulse_d;
            armed_q     <= (state_d == ST_PRIME) || (state_d == ST_RUN);
            triggered_q <= (state_d == ST_DONE);
        end
    end

    assign armed       = armed_q;
    assign triggered   = triggered_q;
    assign trig_pulse  = pulse_q;
    assign stage       = stage_q;
    assign trigger_pos = pos_q;

endmodule
